// File: rtl/branch_update_queue.sv
// branch_update_queue
//   Collects up to three resolved control-transfer reports per cycle,
//   compacts them in slot order into an in-order circular FIFO, and drains
//   up to three entries per cycle onto registered predictor-update ports.
//
// Ports
//   clk, reset                       clock, async active-high reset
//   res_valid_i_k / res_pc_k /       resolution report, slot k = 0..2
//   res_mispredict_k / res_correct_pc_k
//   drain_stall_i                    predictor busy: pop nothing this cycle
//   ready_o                          at least 3 free entries (from registered count)
//   overflow_o                       sticky: a report was dropped
//   count_o                          occupied entries
//   update_prediction_pc_k /         registered update port k = 0..2
//   update_prediction_valid_o_k /
//   misprediction_k / correct_pc_k
module branch_update_queue #(
  parameter int size  = 32,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       res_valid_i_0,
  input  logic                       res_valid_i_1,
  input  logic                       res_valid_i_2,
  input  logic [size-1:0]            res_pc_0,
  input  logic [size-1:0]            res_pc_1,
  input  logic [size-1:0]            res_pc_2,
  input  logic                       res_mispredict_0,
  input  logic                       res_mispredict_1,
  input  logic                       res_mispredict_2,
  input  logic [size-1:0]            res_correct_pc_0,
  input  logic [size-1:0]            res_correct_pc_1,
  input  logic [size-1:0]            res_correct_pc_2,
  input  logic                       drain_stall_i,
  output logic                       ready_o,
  output logic                       overflow_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic [size-1:0]            update_prediction_pc_0,
  output logic [size-1:0]            update_prediction_pc_1,
  output logic [size-1:0]            update_prediction_pc_2,
  output logic                       update_prediction_valid_o_0,
  output logic                       update_prediction_valid_o_1,
  output logic                       update_prediction_valid_o_2,
  output logic                       misprediction_0,
  output logic                       misprediction_1,
  output logic                       misprediction_2,
  output logic [size-1:0]            correct_pc_0,
  output logic [size-1:0]            correct_pc_1,
  output logic [size-1:0]            correct_pc_2
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [size-1:0] mem_pc  [DEPTH];
  logic [size-1:0] mem_cpc [DEPTH];
  logic            mem_mp  [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic          overflow;

  logic            in_valid [3];
  logic [size-1:0] in_pc    [3];
  logic            in_mp    [3];
  logic [size-1:0] in_cpc   [3];

  logic            wr_en  [3];
  logic [size-1:0] wr_pc  [3];
  logic            wr_mp  [3];
  logic [size-1:0] wr_cpc [3];

  logic            out_valid [3];
  logic [size-1:0] out_pc    [3];
  logic            out_mp    [3];
  logic [size-1:0] out_cpc   [3];

  logic [CW-1:0] n_pop;
  logic [CW-1:0] n_valid;
  logic [CW-1:0] free_slots;
  logic [CW-1:0] n_write;
  logic          drop;
  logic [1:0]    idx;

  assign in_valid = '{res_valid_i_0, res_valid_i_1, res_valid_i_2};
  assign in_pc    = '{res_pc_0, res_pc_1, res_pc_2};
  assign in_mp    = '{res_mispredict_0, res_mispredict_1, res_mispredict_2};
  assign in_cpc   = '{res_correct_pc_0, res_correct_pc_1, res_correct_pc_2};

  // Pop amount comes from the registered count only, so entries written at
  // this edge can never be popped at the same edge.
  always_comb begin
    n_pop = '0;
    if (!drain_stall_i) begin
      n_pop = (count >= CW'(3)) ? CW'(3) : count;
    end
    n_valid    = CW'(in_valid[0]) + CW'(in_valid[1]) + CW'(in_valid[2]);
    free_slots = CW'(DEPTH) - count + n_pop;
    n_write    = (n_valid < free_slots) ? n_valid : free_slots;
    drop       = (n_valid > free_slots);
  end

  // Compact valid slots in order 0,1,2 onto write lanes; lanes beyond the
  // free space are left disabled, which is how excess reports get dropped.
  always_comb begin
    idx = 2'd0;
    for (int k = 0; k < 3; k++) begin
      wr_en[k]  = 1'b0;
      wr_pc[k]  = '0;
      wr_mp[k]  = 1'b0;
      wr_cpc[k] = '0;
    end
    for (int s = 0; s < 3; s++) begin
      if (in_valid[s] && (CW'(idx) < n_write)) begin
        wr_en[idx]  = 1'b1;
        wr_pc[idx]  = in_pc[s];
        wr_mp[idx]  = in_mp[s];
        wr_cpc[idx] = in_cpc[s];
        idx         = idx + 2'd1;
      end
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  // When full, writes land on the slots being popped this edge; the pop
  // reads the old contents because both sides are non-blocking.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (wr_en[k]) begin
        mem_pc[tail + PW'(k)]  <= wr_pc[k];
        mem_mp[tail + PW'(k)]  <= wr_mp[k];
        mem_cpc[tail + PW'(k)] <= wr_cpc[k];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        out_valid[k] <= 1'b0;
        out_pc[k]    <= '0;
        out_mp[k]    <= 1'b0;
        out_cpc[k]   <= '0;
      end
    end else begin
      head  <= head + PW'(n_pop);
      tail  <= tail + PW'(n_write);
      count <= count + n_write - n_pop;
      if (drop) begin
        overflow <= 1'b1;
      end
      for (int k = 0; k < 3; k++) begin
        if (CW'(k) < n_pop) begin
          out_valid[k] <= 1'b1;
          out_pc[k]    <= mem_pc[head + PW'(k)];
          out_mp[k]    <= mem_mp[head + PW'(k)];
          out_cpc[k]   <= mem_cpc[head + PW'(k)];
        end else begin
          out_valid[k] <= 1'b0;
        end
      end
    end
  end

  assign ready_o    = (CW'(DEPTH) - count) >= CW'(3);
  assign overflow_o = overflow;
  assign count_o    = count;

  assign update_prediction_valid_o_0 = out_valid[0];
  assign update_prediction_valid_o_1 = out_valid[1];
  assign update_prediction_valid_o_2 = out_valid[2];
  assign update_prediction_pc_0      = out_pc[0];
  assign update_prediction_pc_1      = out_pc[1];
  assign update_prediction_pc_2      = out_pc[2];
  assign misprediction_0             = out_mp[0];
  assign misprediction_1             = out_mp[1];
  assign misprediction_2             = out_mp[2];
  assign correct_pc_0                = out_cpc[0];
  assign correct_pc_1                = out_cpc[1];
  assign correct_pc_2                = out_cpc[2];

endmodule
